// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-back write-allocate data cache controller
// Optional statistics counters are built when DCACHE_STATS_EN is defined.
// Line = 4 x 16-bit words; Addr[2:1] word, Addr[INDEX_BITS+2:3] index, rest is tag.
module dcache_ctrl #(
  parameter int INDEX_BITS = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  input  logic        Rd,
  input  logic        Wr,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        CacheHit,
  output logic        CacheReq,
  output logic        Err,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 13 - INDEX_BITS;
  localparam int AW    = INDEX_BITS + 2;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_COMPARE = 3'd1;
  localparam logic [2:0] S_WB      = 3'd2;
  localparam logic [2:0] S_ALLOC   = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]       r_state;
  logic [2:0]       w_next;

  // Request captured at accept; everything after IDLE works from these copies.
  logic [15:0]      r_addr;
  logic [15:0]      r_wdata;
  logic             r_rd;
  logic             r_wr;

  logic [LINES-1:0] r_valid;
  logic [LINES-1:0] r_dirty;
  logic [TAG_W-1:0] r_tags [LINES];
  logic [15:0]      r_data [LINES*4];

  // Word position within the line during write-back / fill.
  logic [1:0]       r_word;

  logic [INDEX_BITS-1:0] w_idx;
  logic [TAG_W-1:0]      w_tag;
  logic [1:0]            w_off;
  logic                  w_err;
  logic                  w_hit;
  logic                  w_in_mem;
  logic                  w_xfer;
  logic                  w_last;
  logic                  w_store;
  logic [AW-1:0]         w_acc_word;
  logic [AW-1:0]         w_cur_word;

  assign w_idx      = r_addr[INDEX_BITS+2:3];
  assign w_tag      = r_addr[15:INDEX_BITS+3];
  assign w_off      = r_addr[2:1];
  assign w_err      = (r_rd & r_wr) | r_addr[0];
  assign w_hit      = r_valid[w_idx] && (r_tags[w_idx] == w_tag);
  assign w_in_mem   = (r_state == S_WB) || (r_state == S_ALLOC);
  // An ack only counts while we are actually requesting.
  assign w_xfer     = w_in_mem && mem_ack;
  assign w_last     = w_xfer && (r_word == 2'd3);
  assign w_acc_word = {w_idx, w_off};
  assign w_cur_word = {w_idx, r_word};
  // Store completes either on a clean hit in COMPARE or after the fill in DONE.
  assign w_store    = r_wr &&
                      (((r_state == S_COMPARE) && !w_err && w_hit) || (r_state == S_DONE));

  // Next-state decode for the access sequencer.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (Rd | Wr) w_next = S_COMPARE;
      S_COMPARE: begin
        if (w_err || w_hit)                   w_next = S_IDLE;
        else if (r_valid[w_idx] && r_dirty[w_idx]) w_next = S_WB;
        else                                  w_next = S_ALLOC;
      end
      S_WB:      if (w_last) w_next = S_ALLOC;
      S_ALLOC:   if (w_last) w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // State register, request latch and transfer word counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_addr  <= 16'h0000;
      r_wdata <= 16'h0000;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_word  <= 2'd0;
    end else begin
      r_state <= w_next;
      if ((r_state == S_IDLE) && (Rd | Wr)) begin
        r_addr  <= Addr;
        r_wdata <= DataIn;
        r_rd    <= Rd;
        r_wr    <= Wr;
      end
      if (r_state == S_COMPARE) r_word <= 2'd0;
      else if (w_xfer)          r_word <= r_word + 2'd1;
    end
  end

  // Line status bits; reset invalidates every line.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      if ((r_state == S_ALLOC) && w_last) begin
        r_valid[w_idx] <= 1'b1;
        r_dirty[w_idx] <= 1'b0;
      end
      if (w_store) r_dirty[w_idx] <= 1'b1;
    end
  end

  // Tag and data storage; contents are meaningless until the valid bit is set.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if ((r_state == S_ALLOC) && w_xfer) r_data[w_cur_word] <= mem_rdata;
      if ((r_state == S_ALLOC) && w_last) r_tags[w_idx] <= w_tag;
      if (w_store) r_data[w_acc_word] <= r_wdata;
    end
  end

  // Processor-side outputs decoded from state and latched request only.
  always_comb begin
    Stall    = (r_state != S_IDLE);
    CacheReq = (r_state == S_COMPARE);
    Err      = (r_state == S_COMPARE) && w_err;
    CacheHit = (r_state == S_COMPARE) && !w_err && w_hit;
    Done     = ((r_state == S_COMPARE) && (w_err || w_hit)) || (r_state == S_DONE);
    DataOut  = (Done && r_rd && !w_err) ? r_data[w_acc_word] : 16'h0000;
  end

  // Memory-side outputs; address/data only move on an accepted word.
  always_comb begin
    mem_req   = w_in_mem;
    mem_wr    = (r_state == S_WB);
    mem_addr  = 16'h0000;
    mem_wdata = 16'h0000;
    if (r_state == S_WB) begin
      mem_addr  = {r_tags[w_idx], w_idx, r_word, 1'b0};
      mem_wdata = r_data[w_cur_word];
    end else if (r_state == S_ALLOC) begin
      mem_addr  = {w_tag, w_idx, r_word, 1'b0};
    end
  end

`ifdef DCACHE_STATS_EN
  logic [15:0] r_hit_count;
  logic [15:0] r_miss_count;

  // Hit / miss statistics, wrapping at 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit_count  <= 16'h0000;
      r_miss_count <= 16'h0000;
    end else if (Done) begin
      if (CacheHit)  r_hit_count  <= r_hit_count + 16'd1;
      else if (!Err) r_miss_count <= r_miss_count + 16'd1;
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`else
  assign hit_count  = 16'h0000;
  assign miss_count = 16'h0000;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - directed vector bench for dcache_ctrl
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] Addr = 16'h0;
  logic [15:0] DataIn = 16'h0;
  logic        Rd = 1'b0;
  logic        Wr = 1'b0;
  logic [15:0] DataOut;
  logic        Done, Stall, CacheHit, CacheReq, Err;
  logic        mem_req, mem_wr, mem_ack;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic [15:0] hit_count, miss_count;

  int checks = 0;
  int errors = 0;
  int total_acks = 0;

  logic [15:0] mem [0:32767];
  bit          wv  [0:32767];

  always #5 clk = ~clk;

  dcache_ctrl #(.INDEX_BITS(5)) dut (
    .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
    .DataOut(DataOut), .Done(Done), .Stall(Stall), .CacheHit(CacheHit),
    .CacheReq(CacheReq), .Err(Err), .mem_req(mem_req), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .hit_count(hit_count), .miss_count(miss_count)
  );

  // Backing memory: unwritten words read as byte-address ^ 16'hC3C3; ack every cycle.
  assign mem_ack   = mem_req;
  assign mem_rdata = wv[mem_addr[15:1]] ? mem[mem_addr[15:1]] : (mem_addr ^ 16'hC3C3);

  always @(posedge clk) begin
    if (mem_req && mem_ack) begin
      total_acks <= total_acks + 1;
      if (mem_wr) begin
        mem[mem_addr[15:1]] <= mem_wdata;
        wv[mem_addr[15:1]]  <= 1'b1;
      end
    end
  end

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] data;
    int          lat;
    logic        hit;
    logic        err;
    int          acks;
  } vec_t;

  vec_t vt [14];
  int   exp_hits = 0;
  int   exp_miss = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic access(input vec_t t, input string nm);
    int cyc;
    int a0;
    @(negedge clk);
    Rd = t.rd; Wr = t.wr; Addr = t.addr; DataIn = t.wdata;
    a0 = total_acks;
    @(posedge clk);
    #1;
    Rd = 1'b0; Wr = 1'b0;
    @(negedge clk);
    chk({nm, "_req"}, {31'd0, CacheReq}, 32'd1);
    cyc = 1;
    while (!Done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk({nm, "_done"}, {31'd0, Done}, 32'd1);
    chk({nm, "_lat"}, cyc, t.lat);
    chk({nm, "_hit"}, {31'd0, CacheHit}, {31'd0, t.hit});
    chk({nm, "_err"}, {31'd0, Err}, {31'd0, t.err});
    if (t.rd && !t.wr && !t.err) chk({nm, "_data"}, {16'd0, DataOut}, {16'd0, t.data});
    chk({nm, "_acks"}, total_acks - a0, t.acks);
  endtask

  initial begin
    // rd wr addr wdata expected-data latency hit err acks
    vt[0]  = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'h0010 ^ 16'hC3C3, 6,  1'b0, 1'b0, 4};
    vt[1]  = '{1'b1, 1'b0, 16'h0012, 16'h0000, 16'h0012 ^ 16'hC3C3, 1,  1'b1, 1'b0, 0};
    vt[2]  = '{1'b0, 1'b1, 16'h0012, 16'hBEEF, 16'h0000,            1,  1'b1, 1'b0, 0};
    vt[3]  = '{1'b1, 1'b0, 16'h0012, 16'h0000, 16'hBEEF,            1,  1'b1, 1'b0, 0};
    vt[4]  = '{1'b1, 1'b0, 16'h0112, 16'h0000, 16'h0112 ^ 16'hC3C3, 10, 1'b0, 1'b0, 8};
    vt[5]  = '{1'b1, 1'b0, 16'h0012, 16'h0000, 16'hBEEF,            6,  1'b0, 1'b0, 4};
    vt[6]  = '{1'b1, 1'b1, 16'h0012, 16'h5555, 16'h0000,            1,  1'b0, 1'b1, 0};
    vt[7]  = '{1'b1, 1'b0, 16'h0011, 16'h0000, 16'h0000,            1,  1'b0, 1'b1, 0};
    vt[8]  = '{1'b1, 1'b0, 16'h0012, 16'h0000, 16'hBEEF,            1,  1'b1, 1'b0, 0};
    vt[9]  = '{1'b0, 1'b1, 16'h0200, 16'h1234, 16'h0000,            6,  1'b0, 1'b0, 4};
    vt[10] = '{1'b1, 1'b0, 16'h0200, 16'h0000, 16'h1234,            1,  1'b1, 1'b0, 0};
    vt[11] = '{1'b1, 1'b0, 16'h0206, 16'h0000, 16'h0206 ^ 16'hC3C3, 1,  1'b1, 1'b0, 0};
    vt[12] = '{1'b0, 1'b1, 16'h0203, 16'h7777, 16'h0000,            1,  1'b0, 1'b1, 0};
    vt[13] = '{1'b1, 1'b0, 16'h0202, 16'h0000, 16'h0202 ^ 16'hC3C3, 1,  1'b1, 1'b0, 0};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_dataout", {16'd0, DataOut}, 32'd0);
    chk("rst_flags", {26'd0, Done, Stall, CacheHit, CacheReq, Err, mem_req}, 32'd0);
    chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", {16'd0, mem_wdata}, 32'd0);
    chk("rst_counters", {hit_count, miss_count}, 32'd0);

    for (int i = 0; i < 14; i++) begin
      access(vt[i], $sformatf("vec%0d", i));
      if (vt[i].hit) exp_hits++;
      else if (!vt[i].err) exp_miss++;
      if (i == 4) begin
        chk("wb_word1", {16'd0, mem[16'h0012 >> 1]}, 32'h0000BEEF);
        chk("wb_word0", {16'd0, mem[16'h0010 >> 1]}, {16'd0, 16'h0010 ^ 16'hC3C3});
      end
    end

`ifdef DCACHE_STATS_EN
    chk("hit_count", {16'd0, hit_count}, exp_hits);
    chk("miss_count", {16'd0, miss_count}, exp_miss);
`else
    chk("hit_count_off", {16'd0, hit_count}, 32'd0);
    chk("miss_count_off", {16'd0, miss_count}, 32'd0);
`endif

    // Reset during the second fill word of a clean miss.
    @(negedge clk);
    Rd = 1'b1; Addr = 16'h0420;
    @(posedge clk);
    #1 Rd = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_req0", {15'd0, mem_req, mem_addr}, {15'd0, 1'b1, 16'h0420});
    @(negedge clk);
    chk("mid_req1", {15'd0, mem_req, mem_addr}, {15'd0, 1'b1, 16'h0422});
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_req", {30'd0, mem_req, Stall}, 32'd0);
    chk("mid_rst_cnt", {hit_count, miss_count}, 32'd0);
    rst = 1'b0;

    begin
      vec_t t;
      t = '{1'b1, 1'b0, 16'h0420, 16'h0000, 16'h0420 ^ 16'hC3C3, 6, 1'b0, 1'b0, 4};
      access(t, "post_rst_same");
      t = '{1'b1, 1'b0, 16'h0012, 16'h0000, 16'hBEEF, 6, 1'b0, 1'b0, 4};
      access(t, "post_rst_inval");
    end

`ifdef DCACHE_STATS_EN
    chk("post_rst_miss_count", {16'd0, miss_count}, 32'd2);
`else
    chk("post_rst_miss_count", {16'd0, miss_count}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
